// File: rtl/tensor_core_pkg.sv
// Shared sizing, matrix type and loader state encoding for the tensor core input path.
package tensor_core_pkg;

    localparam int DIM    = 4;
    localparam int ELEM_W = 8;

    typedef logic [DIM-1:0][DIM-1:0][ELEM_W-1:0] matrix_t;

    typedef enum logic [1:0] {
        LOAD_A = 2'd0,
        LOAD_B = 2'd1,
        FULL   = 2'd2
    } loader_state_e;

endpackage

// File: rtl/tensor_core_loader.sv
// Collects a serial element stream (A row-major, then B row-major) into two square
// matrices and holds them for the tensor core until the consumer acknowledges.
module tensor_core_loader #(
    parameter int DIM    = tensor_core_pkg::DIM,
    parameter int ELEM_W = tensor_core_pkg::ELEM_W,
    localparam int CNT_W = $clog2(2*DIM*DIM+1)
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  clear,
    input  logic                                  in_valid,
    input  logic [ELEM_W-1:0]                     in_data,
    output logic                                  in_ready,
    output logic [DIM-1:0][DIM-1:0][ELEM_W-1:0]   tensor_core_input1,
    output logic [DIM-1:0][DIM-1:0][ELEM_W-1:0]   tensor_core_input2,
    output logic                                  mats_valid,
    input  logic                                  mats_ack,
    output logic [CNT_W-1:0]                      load_count
);

    import tensor_core_pkg::*;

    localparam int ELEMS = DIM*DIM;

    loader_state_e                          state_q, state_d;
    logic [CNT_W-1:0]                       count_q, count_d;
    logic [DIM-1:0][DIM-1:0][ELEM_W-1:0]    mat_a_q, mat_a_d;
    logic [DIM-1:0][DIM-1:0][ELEM_W-1:0]    mat_b_q, mat_b_d;
    logic [CNT_W-1:0]                       elem_idx;
    logic                                   fire;

    assign in_ready = (state_q != FULL);
    assign fire     = in_valid && in_ready;

    // B elements are addressed relative to the start of the second half of the frame.
    assign elem_idx = (state_q == LOAD_B) ? (count_q - CNT_W'(ELEMS)) : count_q;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        mat_a_d = mat_a_q;
        mat_b_d = mat_b_q;

        if (clear) begin
            state_d = LOAD_A;
            count_d = '0;
            mat_a_d = '0;
            mat_b_d = '0;
        end else begin
            case (state_q)
                LOAD_A: begin
                    if (fire) begin
                        for (int r = 0; r < DIM; r++) begin
                            for (int c = 0; c < DIM; c++) begin
                                if (elem_idx == CNT_W'(r*DIM + c)) begin
                                    mat_a_d[r][c] = in_data;
                                end
                            end
                        end
                        count_d = count_q + 1'b1;
                        if (count_q == CNT_W'(ELEMS-1)) begin
                            state_d = LOAD_B;
                        end
                    end
                end
                LOAD_B: begin
                    if (fire) begin
                        for (int r = 0; r < DIM; r++) begin
                            for (int c = 0; c < DIM; c++) begin
                                if (elem_idx == CNT_W'(r*DIM + c)) begin
                                    mat_b_d[r][c] = in_data;
                                end
                            end
                        end
                        count_d = count_q + 1'b1;
                        if (count_q == CNT_W'(2*ELEMS-1)) begin
                            state_d = FULL;
                        end
                    end
                end
                FULL: begin
                    // Matrices stay put after ack; the next frame overwrites them in place.
                    if (mats_ack) begin
                        state_d = LOAD_A;
                        count_d = '0;
                    end
                end
                default: begin
                    state_d = LOAD_A;
                    count_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= LOAD_A;
            count_q <= '0;
            mat_a_q <= '0;
            mat_b_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            mat_a_q <= mat_a_d;
            mat_b_q <= mat_b_d;
        end
    end

    assign tensor_core_input1 = mat_a_q;
    assign tensor_core_input2 = mat_b_q;
    assign mats_valid         = (state_q == FULL);
    assign load_count         = count_q;

endmodule

// File: tb/tb_tensor_core_loader.sv
// Scoreboard bench for tensor_core_loader: streamed elements are queued and matched
// against the matrices once the loader reports them complete.
module tb_tensor_core_loader;

    localparam int DIM    = 4;
    localparam int ELEM_W = 8;
    localparam int ELEMS  = DIM*DIM;
    localparam int CNT_W  = 6;

    logic                                 clk = 1'b0;
    logic                                 rst_n = 1'b0;
    logic                                 clear = 1'b0;
    logic                                 in_valid = 1'b0;
    logic [ELEM_W-1:0]                    in_data = '0;
    logic                                 mats_ack = 1'b0;
    logic                                 in_ready;
    logic                                 mats_valid;
    logic [DIM-1:0][DIM-1:0][ELEM_W-1:0]  in1, in2;
    logic [CNT_W-1:0]                     load_count;

    int total = 0;
    int bad = 0;
    int exp_cnt = 0;
    logic [ELEM_W-1:0] sb[$];
    logic [ELEM_W-1:0] exp_a[DIM][DIM];
    logic [ELEM_W-1:0] exp_b[DIM][DIM];
    logic [ELEM_W-1:0] stim[2*ELEMS];

    tensor_core_loader #(.DIM(DIM), .ELEM_W(ELEM_W)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .clear              (clear),
        .in_valid           (in_valid),
        .in_data            (in_data),
        .in_ready           (in_ready),
        .tensor_core_input1 (in1),
        .tensor_core_input2 (in2),
        .mats_valid         (mats_valid),
        .mats_ack           (mats_ack),
        .load_count         (load_count)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_status(input string tag, input logic valid_exp, input logic ready_exp, input int cnt_exp);
        check_output({tag, "_mats_valid"}, 32'(mats_valid), 32'(valid_exp));
        check_output({tag, "_in_ready"}, 32'(in_ready), 32'(ready_exp));
        check_output({tag, "_load_count"}, 32'(load_count), 32'(cnt_exp));
    endtask

    task automatic check_zero(input string tag);
        for (int r = 0; r < DIM; r++) begin
            for (int c = 0; c < DIM; c++) begin
                check_output($sformatf("%s_a[%0d][%0d]", tag, r, c), 32'(in1[r][c]), 32'd0);
                check_output($sformatf("%s_b[%0d][%0d]", tag, r, c), 32'(in2[r][c]), 32'd0);
            end
        end
    endtask

    task automatic check_retained(input string tag);
        for (int r = 0; r < DIM; r++) begin
            for (int c = 0; c < DIM; c++) begin
                check_output($sformatf("%s_a[%0d][%0d]", tag, r, c), 32'(in1[r][c]), 32'(exp_a[r][c]));
                check_output($sformatf("%s_b[%0d][%0d]", tag, r, c), 32'(in2[r][c]), 32'(exp_b[r][c]));
            end
        end
    endtask

    task automatic apply_stimulus(input logic [ELEM_W-1:0] v);
        int waited;
        waited = 0;
        in_valid = 1'b1;
        in_data  = v;
        while (!in_ready && waited < 50) begin
            tick();
            waited++;
        end
        if (!in_ready) begin
            check_output("ready_timeout", 32'(in_ready), 32'd1);
        end
        sb.push_back(v);
        exp_cnt++;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic send_frame(input bit gaps, input int ack_at);
        for (int i = 0; i < 2*ELEMS; i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) tick();
            end
            if (i == ack_at) begin
                mats_ack = 1'b1;
                tick();
                mats_ack = 1'b0;
                check_status("ack_outside_full", 1'b0, 1'b1, exp_cnt);
            end
            apply_stimulus(stim[i]);
            if (i < 2*ELEMS-1) begin
                check_output($sformatf("count_after_%0d", i+1), 32'(load_count), 32'(exp_cnt));
            end
        end
    endtask

    task automatic check_full(input string tag);
        check_status(tag, 1'b1, 1'b0, 2*ELEMS);
        if (sb.size() < 2*ELEMS) begin
            check_output({tag, "_sb_size"}, 32'(sb.size()), 32'(2*ELEMS));
        end else begin
            for (int n = 0; n < ELEMS; n++) exp_a[n/DIM][n%DIM] = sb.pop_front();
            for (int n = 0; n < ELEMS; n++) exp_b[n/DIM][n%DIM] = sb.pop_front();
            check_retained(tag);
        end
    endtask

    initial begin
        int acc;

        repeat (2) tick();
        check_status("por", 1'b0, 1'b1, 0);
        rst_n = 1'b1;
        tick();

        // Partial frame, then asynchronous reset between clock edges.
        for (int i = 0; i < 3; i++) apply_stimulus(8'(i + 7));
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check_status("async_reset", 1'b0, 1'b1, 0);
        check_zero("async_reset");
        sb.delete();
        exp_cnt = 0;
        tick();
        rst_n = 1'b1;
        tick();

        // Back-to-back 1..32.
        for (int i = 0; i < 2*ELEMS; i++) stim[i] = 8'(i + 1);
        send_frame(1'b0, -1);
        check_output("a00", 32'(in1[0][0]), 32'd1);
        check_output("a33", 32'(in1[3][3]), 32'd16);
        check_output("b00", 32'(in2[0][0]), 32'd17);
        check_output("b33", 32'(in2[3][3]), 32'd32);
        check_full("seq_frame");

        // Backpressure in FULL.
        in_valid = 1'b1;
        in_data  = 8'hAA;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_status($sformatf("hold%0d", i), 1'b1, 1'b0, 2*ELEMS);
        end
        in_valid = 1'b0;
        check_retained("hold");
        mats_ack = 1'b1;
        tick();
        mats_ack = 1'b0;
        exp_cnt = 0;
        check_status("after_ack", 1'b0, 1'b1, 0);
        check_retained("after_ack");

        // Identity times B through a tensor core model, with random bubbles.
        for (int n = 0; n < ELEMS; n++) stim[n] = (n/DIM == n%DIM) ? 8'd1 : 8'd0;
        for (int n = 0; n < ELEMS; n++) stim[ELEMS + n] = 8'(n + 1);
        send_frame(1'b1, 5);
        check_full("ident_frame");
        for (int i = 0; i < DIM; i++) begin
            for (int j = 0; j < DIM; j++) begin
                acc = 0;
                for (int k = 0; k < DIM; k++) acc += int'(in1[i][k]) * int'(in2[k][j]);
                check_output($sformatf("tc_out[%0d][%0d]", i, j), 32'(acc), 32'(stim[ELEMS + i*DIM + j]));
            end
        end
        mats_ack = 1'b1;
        tick();
        mats_ack = 1'b0;
        exp_cnt = 0;

        // Clear colliding with an 11th valid element.
        for (int i = 0; i < 10; i++) apply_stimulus(8'(100 + i));
        check_output("pre_clear_count", 32'(load_count), 32'd10);
        in_valid = 1'b1;
        in_data  = 8'h55;
        clear    = 1'b1;
        tick();
        clear    = 1'b0;
        in_valid = 1'b0;
        sb.delete();
        exp_cnt = 0;
        check_status("clear_mid", 1'b0, 1'b1, 0);
        check_zero("clear_mid");

        for (int i = 0; i < 2*ELEMS; i++) stim[i] = 8'($urandom_range(0, 255));
        send_frame(1'b0, -1);
        check_full("post_clear_frame");

        // Clear and ack together in FULL.
        clear    = 1'b1;
        mats_ack = 1'b1;
        tick();
        clear    = 1'b0;
        mats_ack = 1'b0;
        check_status("clear_ack", 1'b0, 1'b1, 0);
        check_zero("clear_ack");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
